// File: rtl/security_core_pkg.sv
// Shared definitions for the security datapath: default sizes, default key
// and the keyed byte-rotate/XOR cipher applied between the LIFO and FIFO.
package security_core_pkg;

    localparam int          DEF_WIDTH      = 32;
    localparam int          DEF_LIFO_DEPTH = 8;
    localparam int          DEF_FIFO_DEPTH = 8;
    localparam logic [31:0] DEF_KEY        = 32'h5A5A_5A5A;

    // Rotate left by one byte, then XOR with the key.
    function automatic logic [31:0] cipher(input logic [31:0] x, input logic [31:0] key);
        return {x[23:0], x[31:24]} ^ key;
    endfunction

endpackage

// File: rtl/security_core_sync_fifo.sv
// Synchronous FIFO with count-based full/empty and a registered read port.
// Simultaneous read and write are allowed when full; the read returns the
// old head because the memory read and write share the same edge.
module sync_fifo
    import security_core_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = dout_q;

    // Qualify strobes against occupancy and compute next pointers/count/output.
    always_comb begin
        do_wr   = wr && (!full || rd);
        do_rd   = rd && !empty;
        wptr_d  = do_wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_rd ? rptr_q + 1'b1 : rptr_q;
        dout_d  = do_rd ? mem_q[rptr_q] : dout_q;
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state and read register; cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/security_core.sv
// Plaintext LIFO feeding a ciphered FIFO. The word last popped from the LIFO
// is held in a register (exported for test) and is the cipher input on wr1.
module security_core
    import security_core_pkg::*;
#(
    parameter int          WIDTH      = DEF_WIDTH,
    parameter int          LIFO_DEPTH = DEF_LIFO_DEPTH,
    parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [31:0] KEY        = DEF_KEY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr2,
    input  logic             rd2,
    input  logic             wr1,
    input  logic             rd1,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_out_lifo_test,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int          LAW       = $clog2(LIFO_DEPTH);
    localparam logic [LAW:0] LIFO_FULL = (LAW+1)'(LIFO_DEPTH);

    logic [WIDTH-1:0] stack_q [LIFO_DEPTH];
    logic [LAW:0]     sp_q, sp_d;
    logic [WIDTH-1:0] lifo_out_q, lifo_out_d;
    logic [LAW-1:0]   top_idx;
    logic             push, pop;
    logic [WIDTH-1:0] cipher_w;

    assign data_out_lifo_test = lifo_out_q;
    assign cipher_w           = WIDTH'(cipher(32'(lifo_out_q), KEY));

    // LIFO next state: push has priority over pop; full push / empty pop do nothing.
    always_comb begin
        push       = wr2 && (sp_q != LIFO_FULL);
        pop        = rd2 && !wr2 && (sp_q != '0);
        top_idx    = LAW'(sp_q - 1'b1);
        sp_d       = sp_q;
        lifo_out_d = lifo_out_q;
        if (push) begin
            sp_d = sp_q + 1'b1;
        end else if (pop) begin
            sp_d       = sp_q - 1'b1;
            lifo_out_d = stack_q[top_idx];
        end
    end

    // Stack pointer and popped-word register; cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= '0;
            lifo_out_q <= '0;
        end else begin
            sp_q       <= sp_d;
            lifo_out_q <= lifo_out_d;
        end
    end

    // Stack storage; written at the current pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[LAW-1:0]] <= data_in;
        end
    end

    // Ciphertext queue; enqueues the popped word as it stood before this edge.
    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr1),
        .rd    (rd1),
        .din   (cipher_w),
        .dout  (data_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_security_core.sv
// Scoreboard bench for security_core: a queue-based reference model predicts
// outputs per cycle; a separate monitor compares after each rising edge.
module tb_security_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        wr2, rd2, wr1, rd1;
    logic [31:0] data_out, data_out_lifo_test;
    logic        fifo_full, fifo_empty;

    security_core dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_in            (data_in),
        .wr2                (wr2),
        .rd2                (rd2),
        .wr1                (wr1),
        .rd1                (rd1),
        .data_out           (data_out),
        .data_out_lifo_test (data_out_lifo_test),
        .fifo_full          (fifo_full),
        .fifo_empty         (fifo_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] lifo;
        logic        full;
        logic        empty;
    } exp_t;

    exp_t        sbq[$];
    bit          sb_on = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state
    logic [31:0] m_stk[$];
    logic [31:0] m_fq[$];
    logic [31:0] m_dout = 32'h0;
    logic [31:0] m_lifo = 32'h0;

    function automatic logic [31:0] ref_cipher(input logic [31:0] x);
        logic [31:0] r;
        r = (x << 8) | (x >> 24);
        return r ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of strobes at the falling edge and record the prediction.
    task automatic step(input logic w2, input logic r2, input logic w1, input logic r1,
                        input logic [31:0] d);
        exp_t        e;
        logic [31:0] prev;
        bit          was_full, was_empty;
        @(negedge clk);
        wr2 = w2; rd2 = r2; wr1 = w1; rd1 = r1; data_in = d;
        prev = m_lifo;
        if (w2) begin
            if (m_stk.size() < 8) m_stk.push_back(d);
        end else if (r2 && m_stk.size() > 0) begin
            m_lifo = m_stk.pop_back();
        end
        was_full  = (m_fq.size() == 8);
        was_empty = (m_fq.size() == 0);
        if (r1 && !was_empty) m_dout = m_fq.pop_front();
        if (w1 && (!was_full || r1)) m_fq.push_back(ref_cipher(prev));
        e.dout  = m_dout;
        e.lifo  = m_lifo;
        e.full  = (m_fq.size() == 8);
        e.empty = (m_fq.size() == 0);
        sbq.push_back(e);
        sb_on = 1'b1;
    endtask

    // Monitor: one prediction per rising edge while the scoreboard is active.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb_on) begin
                #1;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got 0 entries expected 1");
                end else begin
                    e = sbq.pop_front();
                    chk("data_out", data_out, e.dout);
                    chk("lifo_test", data_out_lifo_test, e.lifo);
                    chk("fifo_full", {31'h0, fifo_full}, {31'h0, e.full});
                    chk("fifo_empty", {31'h0, fifo_empty}, {31'h0, e.empty});
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dout"}, data_out, 32'h0);
        chk({tag, "_lifo"}, data_out_lifo_test, 32'h0);
        chk({tag, "_full"}, {31'h0, fifo_full}, 32'h0);
        chk({tag, "_empty"}, {31'h0, fifo_empty}, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        wr2 = 1'b0; rd2 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; data_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Main flow with the documented example words
        step(1, 0, 0, 0, 32'h0078696E);
        step(1, 0, 0, 0, 32'h6368616F);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        // LIFO overflow (9th push dropped) then pop with enqueue of prior word
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, $urandom);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);        // dropped: full
        step(0, 0, 1, 1, 32'h0);        // full, both proceed
        step(0, 1, 0, 0, 32'h0);        // pop on empty LIFO
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 32'h0); // last is underflow
        step(1, 1, 0, 0, 32'hDEAD_BEEF); // push wins
        step(0, 1, 0, 0, 32'h0);

        // Pointer wrap: 20 words through both buffers, reads interleaved
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, $urandom);
            step(0, 1, 0, 0, 32'h0);
            step(0, 0, 1, (i > 2) ? 1'b1 : 1'b0, 32'h0);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, ($urandom % 3) == 0,
                 ($urandom % 2) == 0, ($urandom % 3) == 0, $urandom);
        end

        // Fill both buffers, then reset asynchronously between clock edges
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, $urandom);
        @(posedge clk);
        #3;
        sb_on = 1'b0;
        wr2 = 1'b0; rd2 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        m_stk.delete();
        m_fq.delete();
        m_dout = 32'h0;
        m_lifo = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 1, 32'h0);          // both buffers must now be empty
        for (int i = 0; i < 60; i++) begin
            step(($urandom % 2) == 0, ($urandom % 3) == 0,
                 ($urandom % 2) == 0, ($urandom % 3) == 0, $urandom);
        end

        @(posedge clk);
        #3;
        sb_on = 1'b0;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/security_core.md
# security_core

Two-stage buffering block for the security datapath. Plaintext words are pushed onto a LIFO (stack). They are popped one at a time into a holding register and scrambled with a keyed byte-rotate/XOR cipher. The scrambled words are then queued in a FIFO for downstream readout. It sits between the plaintext source and the ciphertext consumer; the LIFO holding register is exported for test visibility.

## Interface
Parameters:
- WIDTH, 32, data word width (cipher defined for 32)
- LIFO_DEPTH, 8, stack entries (power of 2)
- FIFO_DEPTH, 8, queue entries (power of 2)
- KEY, 32'h5A5A_5A5A, cipher XOR key

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  WIDTH  plaintext word for LIFO push
- wr2  in  1  push data_in onto LIFO
- rd2  in  1  pop LIFO top into data_out_lifo_test
- wr1  in  1  push cipher(data_out_lifo_test) into FIFO
- rd1  in  1  pop FIFO head into data_out
- data_out  out  WIDTH  last word read from FIFO (registered)
- data_out_lifo_test  out  WIDTH  last word popped from LIFO (registered)
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- fifo_empty  out  1  FIFO holds 0 words

## Operation
- Cipher: c = {x[23:0], x[31:24]} ^ KEY. This is a rotate left by 8, then XOR.
- LIFO:
  - wr2 with stack not full: store data_in at sp, then sp+1.
  - wr2 with stack full: the write is dropped.
  - rd2 (wr2 low) with stack not empty: data_out_lifo_test <= entry[sp-1], then sp-1.
  - rd2 with stack empty: no change; data_out_lifo_test holds.
  - wr2 and rd2 together: push wins, pop is ignored.
- FIFO:
  - wr1 with FIFO not full: write cipher(data_out_lifo_test) at wptr.
  - rd1 with FIFO not empty: data_out <= mem[rptr].
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by a count register 0..FIFO_DEPTH.
  - wr1 with FIFO full and rd1 low: the write is dropped.
  - rd1 with FIFO empty: no change; data_out holds.
  - wr1 and rd1 together, not empty and not full: both proceed, count unchanged.
  - wr1 and rd1 together on full: both proceed; the read returns the old head.
  - wr1 and rd1 together on empty: write only.
- wr1 uses the value of data_out_lifo_test present before the clock edge. rd2 and wr1 in the same cycle therefore enqueue the previous popped word.

## Timing
- Reset (async assert, sync-to-clk deassert by environment):
  - data_out = 0, data_out_lifo_test = 0.
  - FIFO and LIFO pointers and counts = 0.
  - fifo_empty = 1, fifo_full = 0.
  - Memory contents need not be cleared.
- All state updates occur on the rising edge of clk.
- Pop latency is 1 cycle for both LIFO and FIFO: the output is valid after the edge that samples rd1/rd2.
- fifo_full and fifo_empty are decoded combinationally from the count register. They reflect the state after each edge.
- Reset mid-operation empties both buffers immediately; any pending strobes are discarded.

## Structure
- Shared package: the cipher function (rotate + XOR), default KEY, and default depth constants.
- One sub-module is natural: sync_fifo (WIDTH, DEPTH; wr, rd, din, dout, full, empty).
- The LIFO is simple enough to stay inline in security_core.

## Test plan
- Reset: hold rst_n=0 -> all outputs 0, fifo_empty=1, fifo_full=0; asserting rst_n low mid-cycle clears state without waiting for clk.
- Main flow:
  - Push 32'h0078696E then 32'h6368616F via wr2.
  - rd2 -> data_out_lifo_test = 32'h6368616F.
  - wr1 -> fifo_empty = 0.
  - rd2 -> data_out_lifo_test = 32'h0078696E.
  - wr1.
  - rd1 -> data_out = 32'h323B3539.
  - rd1 -> data_out = 32'h2233345A, fifo_empty = 1.
- FIFO full:
  - 8 wr1 strobes -> fifo_full = 1.
  - A 9th wr1 -> dropped; 8 reads return only the 8 written words.
  - wr1 and rd1 together when full -> count stays 8.
- Underflow: rd1 on empty FIFO and rd2 on empty LIFO -> data_out and data_out_lifo_test unchanged.
- LIFO order and overflow:
  - Push 9 words -> the 9th is dropped.
  - 8 pops return the words in reverse order.
  - wr2 and rd2 together -> push only.
- Pointer wrap: interleave writes and reads over 20 words -> FIFO order preserved across wrap, flags correct throughout.
